// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through dcache load queue: controller port structs,
// queue entry layout and load-queue FSM states.
package wt_cache_pkg;

    localparam int PLEN               = 56;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;
    localparam int LDQ_DEFAULT_DEPTH  = 4;
    // Widest transaction ID an entry can carry.
    localparam int LDQ_ID_WIDTH       = 3;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef enum logic [1:0] {
        LDQ_IDLE,
        LDQ_TAG,
        LDQ_WAIT,
        LDQ_KILL
    } ldq_state_e;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]   tag;
        logic [DCACHE_INDEX_WIDTH-1:0] idx;
        logic [1:0]                    size;
        logic                          sign;
        logic [LDQ_ID_WIDTH-1:0]       id;
    } ldq_entry_t;

    function automatic logic ldq_is_aligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return off[0] == 1'b0;
            2'd2:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/wt_dcache_ld_align.sv
// Byte-aligns a 64-bit read word by offset, truncates to the access size and
// sign- or zero-extends the result.
module wt_dcache_ld_align (
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [63:0] result
);

    logic [63:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (size)
            2'd0:    result = {{56{sign & shifted[7]}},  shifted[7:0]};
            2'd1:    result = {{48{sign & shifted[15]}}, shifted[15:0]};
            2'd2:    result = {{32{sign & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/wt_dcache_ld_queue.sv
// Load-request FIFO in front of the write-through dcache read controller.
// Optional WT_DCACHE_LDQ_PERF_EN adds saturating issue/kill/wait-cycle counters.
module wt_dcache_ld_queue
    import wt_cache_pkg::*;
#(
    parameter int LdqDepth  = LDQ_DEFAULT_DEPTH,
    parameter int TxIdWidth = LDQ_ID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [PLEN-1:0]      ld_paddr_i,
    input  logic [1:0]           ld_size_i,
    input  logic                 ld_sign_i,
    input  logic [TxIdWidth-1:0] ld_id_i,
    output logic                 rsp_valid_o,
    output logic [TxIdWidth-1:0] rsp_id_o,
    output logic [63:0]          rsp_data_o,
    output dcache_req_i_t        req_port_o,
    input  dcache_req_o_t        req_port_i,
    output logic                 empty_o
`ifdef WT_DCACHE_LDQ_PERF_EN
    ,
    output logic [31:0]          perf_issued_o,
    output logic [31:0]          perf_killed_o,
    output logic [31:0]          perf_wait_cycles_o
`endif
);

    localparam int PtrW = $clog2(LdqDepth);
    localparam int CntW = PtrW + 1;

    if (TxIdWidth > LDQ_ID_WIDTH) begin : g_id_width_check
        $error("TxIdWidth exceeds the entry ID width");
    end

    logic [PtrW-1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]             count_reg;
    ldq_entry_t                  entry_reg [LdqDepth];
    logic [LdqDepth-1:0]         entry_we;
    ldq_entry_t                  head, new_entry;
    ldq_state_e                  state_reg, state_next;

    logic [DCACHE_TAG_WIDTH-1:0] inflight_tag_reg;
    logic [2:0]                  inflight_off_reg;
    logic [1:0]                  inflight_size_reg;
    logic                        inflight_sign_reg;
    logic [TxIdWidth-1:0]        inflight_id_reg;

    logic                        rsp_valid_reg;
    logic [TxIdWidth-1:0]        rsp_id_reg;
    logic [63:0]                 rsp_data_reg;
    logic [63:0]                 aligned_data;

    logic full, queue_empty, push, pop, in_read, rvalid, issue, gnt, rsp_fire;

    assign full        = count_reg == CntW'(LdqDepth);
    assign queue_empty = count_reg == '0;
    assign ld_ready_o  = !full && !flush_i;
    assign push        = ld_valid_i && ld_ready_o;
    assign in_read     = (state_reg == LDQ_TAG) || (state_reg == LDQ_WAIT);
    assign rvalid      = req_port_i.data_rvalid;
    // A new read may overlap the cycle in which the previous one returns data.
    assign issue       = !queue_empty && !flush_i && ((state_reg == LDQ_IDLE) || (in_read && rvalid));
    assign gnt         = issue && req_port_i.data_gnt;
    assign pop         = gnt;
    assign rsp_fire    = in_read && rvalid && !flush_i;
    assign head        = entry_reg[rd_ptr_reg];

    assign new_entry = '{
        tag:  ld_paddr_i[PLEN-1:DCACHE_INDEX_WIDTH],
        idx:  ld_paddr_i[DCACHE_INDEX_WIDTH-1:0],
        size: ld_size_i,
        sign: ld_sign_i,
        id:   LDQ_ID_WIDTH'(ld_id_i)
    };

    for (genvar gi = 0; gi < LdqDepth; gi++) begin : g_entry_we
        assign entry_we[gi] = push && (wr_ptr_reg == PtrW'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LdqDepth; i++) begin
            if (entry_we[i]) begin
                entry_reg[i] <= new_entry;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            count_reg <= count_reg + CntW'(push) - CntW'(pop);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LDQ_IDLE: if (gnt) state_next = LDQ_TAG;
            // A flushed read that has not returned must be drained in KILL so
            // its late rvalid is never mistaken for a live response.
            LDQ_TAG, LDQ_WAIT: begin
                if (rvalid)       state_next = gnt ? LDQ_TAG : LDQ_IDLE;
                else if (flush_i) state_next = LDQ_KILL;
                else              state_next = LDQ_WAIT;
            end
            LDQ_KILL: if (rvalid) state_next = LDQ_IDLE;
            default:  state_next = LDQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= LDQ_IDLE;
            inflight_tag_reg  <= '0;
            inflight_off_reg  <= '0;
            inflight_size_reg <= '0;
            inflight_sign_reg <= 1'b0;
            inflight_id_reg   <= '0;
            rsp_valid_reg     <= 1'b0;
            rsp_id_reg        <= '0;
            rsp_data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= rsp_fire;
            if (gnt) begin
                inflight_tag_reg  <= head.tag;
                inflight_off_reg  <= head.idx[2:0];
                inflight_size_reg <= head.size;
                inflight_sign_reg <= head.sign;
                inflight_id_reg   <= TxIdWidth'(head.id);
            end
            if (rsp_fire) begin
                rsp_id_reg   <= inflight_id_reg;
                rsp_data_reg <= aligned_data;
            end
        end
    end

    wt_dcache_ld_align u_align (
        .data   (req_port_i.data_rdata),
        .offset (inflight_off_reg),
        .size   (inflight_size_reg),
        .sign   (inflight_sign_reg),
        .result (aligned_data)
    );

    always_comb begin
        req_port_o          = '0;
        req_port_o.data_req = issue;
        if (issue) begin
            req_port_o.address_index = head.idx;
            req_port_o.data_size     = head.size;
        end
        if ((state_reg == LDQ_TAG) && !flush_i) begin
            req_port_o.tag_valid   = 1'b1;
            req_port_o.address_tag = inflight_tag_reg;
        end
        req_port_o.kill_req = (state_reg == LDQ_KILL) || (in_read && flush_i);
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_id_o    = rsp_id_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign empty_o     = queue_empty && (state_reg == LDQ_IDLE);

`ifdef WT_DCACHE_LDQ_PERF_EN
    logic [31:0] perf_issued_reg, perf_killed_reg, perf_wait_reg;
    logic        kill_event;

    assign kill_event = ((state_next == LDQ_KILL) && (state_reg != LDQ_KILL))
                     || (req_port_o.kill_req && rvalid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_reg <= '0;
            perf_killed_reg <= '0;
            perf_wait_reg   <= '0;
        end else begin
            if (gnt && (perf_issued_reg != '1))        perf_issued_reg <= perf_issued_reg + 32'd1;
            if (kill_event && (perf_killed_reg != '1)) perf_killed_reg <= perf_killed_reg + 32'd1;
            if (((state_reg == LDQ_WAIT) || (state_reg == LDQ_KILL)) && (perf_wait_reg != '1))
                perf_wait_reg <= perf_wait_reg + 32'd1;
        end
    end

    assign perf_issued_o      = perf_issued_reg;
    assign perf_killed_o      = perf_killed_reg;
    assign perf_wait_cycles_o = perf_wait_reg;
`endif

    a_load_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> ldq_is_aligned(ld_paddr_i[2:0], ld_size_i));

endmodule

// File: tb/tb_wt_dcache_ld_queue.sv
// Scoreboard bench for wt_dcache_ld_queue: the bench plays the dcache read
// controller and predicts responses from a queue-level model of the loads.
module tb_wt_dcache_ld_queue;
    import wt_cache_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDW   = 3;
    localparam int IDXW  = DCACHE_INDEX_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i, flush_i, ld_valid_i, ld_ready_o, ld_sign_i;
    logic [PLEN-1:0]      ld_paddr_i;
    logic [1:0]           ld_size_i;
    logic [IDW-1:0]       ld_id_i, rsp_id_o;
    logic                 rsp_valid_o, empty_o;
    logic [63:0]          rsp_data_o;
    dcache_req_i_t        req_port_o;
    dcache_req_o_t        req_port_i;
`ifdef WT_DCACHE_LDQ_PERF_EN
    logic [31:0]          perf_issued, perf_killed, perf_wait;
`endif

    wt_dcache_ld_queue #(.LdqDepth(DEPTH), .TxIdWidth(IDW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_paddr_i  (ld_paddr_i),
        .ld_size_i   (ld_size_i),
        .ld_sign_i   (ld_sign_i),
        .ld_id_i     (ld_id_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .req_port_o  (req_port_o),
        .req_port_i  (req_port_i),
        .empty_o     (empty_o)
`ifdef WT_DCACHE_LDQ_PERF_EN
        ,
        .perf_issued_o      (perf_issued),
        .perf_killed_o      (perf_killed),
        .perf_wait_cycles_o (perf_wait)
`endif
    );

    typedef struct {
        logic [PLEN-1:0] paddr;
        logic [1:0]      size;
        logic            sign;
        logic [IDW-1:0]  id;
    } load_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        int             cyc;
    } exp_t;

    typedef enum {P_NONE, P_TAG, P_WAIT, P_KILL} phase_e;

    load_t  mq[$];      // loads accepted but not yet granted
    exp_t   eq[$];      // responses the DUT still owes
    phase_e ph;         // protocol phase of the read the controller holds
    load_t  cur;
    int     lat;
    int     checks = 0, failures = 0, cyc = 0;
    bit     rd_force_en = 0, exp_force_en = 0, stray_rv = 0;
    logic [63:0] rd_force, exp_force;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Byte-wise extraction, independent of any shift formulation.
    function automatic logic [63:0] model_ext(input load_t l, input logic [63:0] rd);
        int nbytes, off;
        logic [63:0] v;
        nbytes = 1 << l.size;
        off    = int'(l.paddr[2:0]);
        v      = '0;
        for (int b = 0; b < nbytes; b++) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (l.sign && v[8*nbytes-1])
            for (int b = nbytes; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic load_t mk(input logic [PLEN-1:0] pa, input logic [1:0] sz,
                                 input logic sg, input logic [IDW-1:0] id);
        load_t l;
        l.paddr = pa; l.size = sz; l.sign = sg; l.id = id;
        return l;
    endfunction

    function automatic load_t rand_load();
        load_t l;
        int off;
        l.size  = 2'($urandom_range(0, 3));
        l.paddr = PLEN'({$urandom, $urandom});
        off     = $urandom_range(0, 7) & ~((1 << l.size) - 1);
        l.paddr[2:0] = 3'(off);
        l.sign  = 1'($urandom_range(0, 1));
        l.id    = IDW'($urandom);
        return l;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid_o) begin
            if (eq.size() == 0) begin
                chk("unexpected_rsp_valid", rsp_valid_o, 1'b0);
            end else begin
                e = eq.pop_front();
                $display("rsp cycle=%0d id=%0d data=%h", cyc, rsp_id_o, rsp_data_o);
                chk("rsp_latency", cyc, e.cyc + 1);
                chk("rsp_id", rsp_id_o, e.id);
                chk("rsp_data", rsp_data_o, e.data);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_id", rsp_id_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_req_port_zero", req_port_o == '0, 1);
        chk("rst_ld_ready", ld_ready_o, 1);
        chk("rst_empty", empty_o, 1);
    endtask

    // One clock cycle: drive inputs at the falling edge, act as controller.
    task automatic do_cycle(input bit lv, input load_t ld, input bit fl,
                            input bit gnt_ok, input int new_lat);
        bit rv, exp_req, gnt, push;
        logic [63:0] rd;
        exp_t e;
        @(negedge clk);
        rv = ((ph != P_NONE) && (lat == 0)) || stray_rv;
        stray_rv = 0;
        rd = {$urandom, $urandom};
        if (rv && rd_force_en) begin rd = rd_force; rd_force_en = 0; end
        flush_i    = fl;
        ld_valid_i = lv;
        ld_paddr_i = ld.paddr;
        ld_size_i  = ld.size;
        ld_sign_i  = ld.sign;
        ld_id_i    = ld.id;
        req_port_i.data_rvalid = rv;
        req_port_i.data_rdata  = rd;
        req_port_i.data_gnt    = 1'b0;
        #1;
        exp_req = (mq.size() != 0) && !fl &&
                  ((ph == P_NONE) || (((ph == P_TAG) || (ph == P_WAIT)) && rv));
        chk("data_req", req_port_o.data_req, exp_req);
        chk("ld_ready", ld_ready_o, (mq.size() < DEPTH) && !fl);
        chk("empty", empty_o, (mq.size() == 0) && (ph == P_NONE));
        chk("write_fields", {req_port_o.data_we, req_port_o.data_be}, 0);
        chk("wdata", req_port_o.data_wdata, 0);
        case (ph)
            P_TAG: begin
                chk("tag_valid", req_port_o.tag_valid, !fl);
                chk("kill_req", req_port_o.kill_req, fl);
                if (!fl) chk("address_tag", req_port_o.address_tag, cur.paddr[PLEN-1:IDXW]);
            end
            P_WAIT: begin
                chk("tag_valid", req_port_o.tag_valid, 0);
                chk("kill_req", req_port_o.kill_req, fl);
            end
            P_KILL: begin
                chk("tag_valid", req_port_o.tag_valid, 0);
                chk("kill_req", req_port_o.kill_req, 1);
            end
            default: begin
                chk("tag_valid", req_port_o.tag_valid, 0);
                chk("kill_req", req_port_o.kill_req, 0);
            end
        endcase
        gnt = req_port_o.data_req && exp_req && gnt_ok;
        req_port_i.data_gnt = gnt;
        if (gnt) begin
            chk("address_index", req_port_o.address_index, mq[0].paddr[IDXW-1:0]);
            chk("data_size", req_port_o.data_size, mq[0].size);
        end
        push = lv && (mq.size() < DEPTH) && !fl;
        $display("cyc=%0d ph=%s lv=%0d push=%0d fl=%0d rv=%0d gnt=%0d q=%0d",
                 cyc, ph.name(), lv, push, fl, rv, gnt, mq.size());
        if (rv && ((ph == P_TAG) || (ph == P_WAIT)) && !fl) begin
            e.id   = cur.id;
            e.data = exp_force_en ? exp_force : model_ext(cur, rd);
            e.cyc  = cyc;
            exp_force_en = 0;
            eq.push_back(e);
        end
        if (rv) ph = P_NONE;
        else if ((ph == P_TAG) || (ph == P_WAIT)) begin
            ph = fl ? P_KILL : P_WAIT;
            lat--;
        end else if (ph == P_KILL) lat--;
        if (gnt) begin
            cur = mq.pop_front();
            ph  = P_TAG;
            lat = new_lat;
        end
        if (fl) mq.delete();
        else if (push) mq.push_back(ld);
    endtask

    task automatic idle(input int n, input bit gnt_ok);
        load_t x;
        x = mk('0, 0, 0, 0);
        for (int i = 0; i < n; i++) do_cycle(0, x, 0, gnt_ok, 0);
    endtask

    load_t ld, x;

    initial begin
        rst_i = 1; flush_i = 0; ld_valid_i = 0; ld_paddr_i = '0; ld_size_i = '0;
        ld_sign_i = 0; ld_id_i = '0; req_port_i = '0;
        ph = P_NONE; lat = 0;
        x = mk('0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_i = 0;

        // Hit: sign-extended word at offset 4, rvalid in the TAG cycle.
        ld = mk(56'h8000_0004, 2'd2, 1'b1, 3'd5);
        do_cycle(1, ld, 0, 0, 0);
        do_cycle(0, x, 0, 1, 0);
        rd_force = 64'h8765_4321_0000_0000; rd_force_en = 1;
        exp_force = 64'hFFFF_FFFF_8765_4321; exp_force_en = 1;
        idle(3, 0);

        // Back-to-back hits; fifth push meets a full queue.
        for (int i = 0; i < 5; i++) begin
            ld = rand_load();
            ld.id = IDW'(i);
            do_cycle(1, ld, 0, 0, 0);
        end
        idle(8, 1);

        // Miss: zero-extended byte at offset 7, rvalid 20 cycles later.
        ld = mk(56'h0000_1234_5677, 2'd0, 1'b0, 3'd2);
        do_cycle(1, ld, 0, 0, 0);
        do_cycle(0, x, 0, 1, 20);
        rd_force = 64'hAB00_0000_0000_0000; rd_force_en = 1;
        exp_force = 64'h0000_0000_0000_00AB; exp_force_en = 1;
        idle(24, 0);

        // Flush in TAG with rvalid in the same cycle.
        do_cycle(1, rand_load(), 0, 0, 0);
        do_cycle(0, x, 0, 1, 0);
        do_cycle(0, x, 1, 0, 0);
        idle(2, 0);

        // Flush in WAIT, drained through KILL; the push in the flush cycle is dropped.
        do_cycle(1, rand_load(), 0, 0, 0);
        do_cycle(0, x, 0, 1, 12);
        idle(2, 0);
        do_cycle(1, rand_load(), 1, 0, 0);
        idle(14, 0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            do_cycle(1'($urandom_range(0, 1)), rand_load(), $urandom_range(0, 39) == 0,
                     $urandom_range(0, 9) < 7,
                     ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8)));
        end
        for (int i = 0; i < 300 && !((ph == P_NONE) && (mq.size() == 0)); i++) idle(1, 1);
        idle(2, 0);

        // Reset in WAIT with three loads queued; a later rvalid is ignored.
        for (int i = 0; i < 4; i++) do_cycle(1, rand_load(), 0, 0, 0);
        do_cycle(0, x, 0, 1, 40);
        idle(2, 0);
        @(negedge clk);
        rst_i = 1; flush_i = 0; ld_valid_i = 0; req_port_i = '0;
        @(negedge clk);
        check_reset_outputs();
        rst_i = 0;
        mq.delete(); eq.delete(); ph = P_NONE; lat = 0;
        stray_rv = 1;
        idle(4, 0);

        // Final drain and scoreboard check.
        for (int i = 0; i < 20; i++) do_cycle(1'($urandom_range(0, 1)), rand_load(), 0, 1, 0);
        for (int i = 0; i < 300 && !((ph == P_NONE) && (mq.size() == 0)); i++) idle(1, 1);
        idle(3, 0);
        chk("drain_empty", empty_o, 1);
        chk("scoreboard_drained", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
